// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide, sign fixup.
// Define MDU_EARLY_TERM_EN to let multiplies finish once the remaining multiplier bits are zero.
module mult_div_unit #(
    parameter int unsigned data_width  = 32,
    parameter int unsigned count_width = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [data_width-1:0] operand_a,
    input  logic [data_width-1:0] operand_b,
    input  logic                  wr_hi,
    input  logic                  wr_lo,
    input  logic [data_width-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [data_width-1:0] hi,
    output logic [data_width-1:0] lo,
    output logic                  div_by_zero
);

    localparam int unsigned msb = data_width - 1;

`ifdef MDU_EARLY_TERM_EN
    localparam bit early_term = 1'b1;
`else
    localparam bit early_term = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StCalc, StFixup} state_e;

    state_e                  state;
    logic                    is_div_q;
    logic                    sign_q;
    logic                    sign_r;
    logic [data_width-1:0]   raw_a;
    logic [data_width-1:0]   b_mag;
    logic [data_width-1:0]   quo;
    logic [data_width-1:0]   rem;
    logic [2*data_width-1:0] prod;
    logic [2*data_width-1:0] mcand;
    logic [count_width-1:0]  counter;

    logic [data_width-1:0]   a_mag_c;
    logic [data_width-1:0]   b_mag_c;
    logic [data_width:0]     trial;
    logic                    calc_last;
    logic [2*data_width-1:0] prod_fix;
    logic [data_width-1:0]   quo_fix;
    logic [data_width-1:0]   rem_fix;

    always_comb begin
        a_mag_c   = (op[0] && operand_a[msb]) ? -operand_a : operand_a;
        b_mag_c   = (op[0] && operand_b[msb]) ? -operand_b : operand_b;
        // quo doubles as multiplier (shifting right) or dividend/quotient (shifting left)
        trial     = {rem, quo[msb]} - {1'b0, b_mag};
        calc_last = (counter == count_width'(data_width - 1)) ||
                    (early_term && !is_div_q && (quo[msb:1] == '0));
        prod_fix  = sign_q ? -prod : prod;
        quo_fix   = sign_q ? -quo : quo;
        rem_fix   = sign_r ? -rem : rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            is_div_q    <= 1'b0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            raw_a       <= '0;
            b_mag       <= '0;
            quo         <= '0;
            rem         <= '0;
            prod        <= '0;
            mcand       <= '0;
            counter     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        is_div_q    <= op[1];
                        sign_q      <= op[0] & (operand_a[msb] ^ operand_b[msb]);
                        sign_r      <= op[0] & operand_a[msb];
                        raw_a       <= operand_a;
                        b_mag       <= b_mag_c;
                        quo         <= op[1] ? a_mag_c : b_mag_c;
                        rem         <= '0;
                        prod        <= '0;
                        mcand       <= {{data_width{1'b0}}, a_mag_c};
                        counter     <= '0;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state       <= (early_term && !op[1] && b_mag_c == '0) ? StFixup : StCalc;
                    end else begin
                        if (wr_hi) hi <= wr_data;
                        if (wr_lo) lo <= wr_data;
                    end
                end
                StCalc: begin
                    counter <= counter + 1'b1;
                    if (is_div_q) begin
                        if (!trial[data_width]) rem <= trial[msb:0];
                        else                    rem <= {rem[msb-1:0], quo[msb]};
                        quo <= {quo[msb-1:0], ~trial[data_width]};
                    end else begin
                        if (quo[0]) prod <= prod + mcand;
                        mcand <= mcand << 1;
                        quo   <= quo >> 1;
                    end
                    if (calc_last) state <= StFixup;
                end
                StFixup: begin
                    if (is_div_q) begin
                        if (b_mag == '0) begin
                            hi          <= raw_a;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end else begin
                        hi <= prod_fix[2*data_width-1:data_width];
                        lo <= prod_fix[msb:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit directly downstream of the 32-entry register file.
- Consumes read_data_1/read_data_2 as operand_a/operand_b for MULT, MULTU, DIV and DIVU.
- Holds results in architectural HI/LO registers, which feed the MFHI/MFLO path back to the register-file write_data mux.
- The control FSM stalls on busy and advances on done.

Parameters:
- data_width, 32, operand and HI/LO width (must be even, ≥4).
- count_width, 6, iteration counter width (≥ clog2(data_width)+1).

Ports:
- clk  input  1  rising-edge clock, shared with register file
- rst  input  1  asynchronous active-high reset
- start  input  1  begin operation; sampled only in IDLE
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- operand_a  input  data_width  rs value (multiplicand / dividend)
- operand_b  input  data_width  rt value (multiplier / divisor)
- wr_hi  input  1  MTHI strobe
- wr_lo  input  1  MTLO strobe
- wr_data  input  data_width  MTHI/MTLO data
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- hi  output  data_width  HI register (product high / remainder)
- lo  output  data_width  LO register (product low / quotient)
- div_by_zero  output  1  last divide had operand_b == 0

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, on port rst.
- Reset (async, immediate):
  - state=IDLE; hi=0, lo=0; busy=0, done=0, div_by_zero=0; counter=0.
  - Asserting rst mid-operation aborts the operation; no partial result is kept.
- States:
  - IDLE→CALC on start.
  - CALC→FIXUP when counter reaches data_width.
  - FIXUP→IDLE unconditionally.
- Start (edge N, state IDLE, start=1):
  - Latch op, magnitudes |a| and |b| (signed ops only; unsigned ops pass through), sign_q=a[msb]^b[msb], sign_r=a[msb].
  - Clear div_by_zero; counter=0; busy=1 from edge N.
- CALC, multiply: radix-2 shift-add, one multiplier bit per cycle, 2*data_width accumulator.
- CALC, divide: restoring division, one quotient bit per cycle.
- CALC duration: exactly data_width cycles (edges N+1..N+data_width).
- FIXUP (edge N+data_width+1):
  - Apply signs. Signed MULT: 2*data_width product negated if sign_q.
  - Signed DIV: quotient negated if sign_q; remainder negated if sign_r.
  - Write hi/lo.
  - done=1 and busy=0 for exactly the cycle after that edge.
- Latency: done is visible data_width+2 cycles after the start sample edge; hi/lo are valid in the same cycle as done.
- hi/lo stability: hi/lo hold their old values throughout CALC; they are updated only at FIXUP (or by wr_hi/wr_lo).
- Divide by zero (operand_b==0):
  - Same latency as a normal divide.
  - At FIXUP: hi=operand_a as latched (raw, unsigned), lo=all ones, div_by_zero=1.
  - div_by_zero holds until the next accepted start or rst.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0 (wraps, no flag).
- start while busy: ignored, no queuing.
- start on the same cycle done is high: accepted (state is already IDLE).
- wr_hi / wr_lo:
  - Write hi/lo from wr_data at the clock edge, only in IDLE with start=0.
  - Both strobes may be high together.
  - Ignored while busy.
  - If start and a write strobe are high in the same cycle, start wins and the write is dropped.
- Widths: all arithmetic is modulo 2*data_width (multiply) or data_width (divide); no saturation.

Optional Feature:
- MDU_EARLY_TERM_EN defined:
  - Multiply CALC exits to FIXUP as soon as the remaining unshifted multiplier bits are all zero.
  - Minimum multiply latency is 2 cycles (multiplier magnitude 0).
  - Divide latency is unchanged.
- MDU_EARLY_TERM_EN undefined: fixed data_width+2 latency for all ops.

Test Plan:
- MULTU 0xFFFFFFFF×0xFFFFFFFF → done at start+34, hi=0xFFFFFFFE, lo=0x00000001, busy high exactly 33 cycles.
- MULT 0xFFFFFFFD(-3)×0x00000007 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULTU of the same operands → hi=0x00000006, lo=0xFFFFFFEB.
- DIV 0xFFFFFFF9(-7)/0x00000002 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 → lo=14, hi=2; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 0x12345678/0 → div_by_zero=1, hi=0x12345678, lo=0xFFFFFFFF, same latency; next MULTU start clears div_by_zero.
- Reset and collisions:
  - rst pulse at start+10 → busy/done/hi/lo=0 immediately, no done pulse follows.
  - start during busy is ignored (hi/lo reflect the first op only).
  - wr_lo=1, wr_data=0xCAFEBABE in IDLE → lo=0xCAFEBABE next cycle.
  - start+wr_hi in the same cycle → wr_hi dropped.
- With MDU_EARLY_TERM_EN: MULTU 5×1 → done at start+3; MULTU 5×0 → done at start+2 with hi=lo=0; DIVU latency still 34.
